div_issue_ctrl: RTL
===================

// Module: div_issue_ctrl
// PURPOSE
//  Execute-stage front end for RV32M DIV/DIVU/REM/REMU; sits directly upstream of the multi-cycle divider.
//  Decodes funct3, short-circuits divide-by-zero, signed-overflow and repeated-operand cases, and
//  launches the divider otherwise. Returns quotient or remainder, and stalls the pipeline via busy until done.
// PARAMETERS
//  XLEN      32  operand/result width
//  CACHE_EN  1   1 = reuse last divider q/r when operands and signedness match (DIV followed by REM)
// PORTS
//  clk           in   1     clock, rising edge
//  nrst          in   1     asynchronous active-low reset
//  req_valid     in   1     div-class instruction in execute; held high until done
//  funct3        in   3     100 DIV, 101 DIVU, 110 REM, 111 REMU
//  rs1_val       in   XLEN  dividend
//  rs2_val       in   XLEN  divisor
//  flush         in   1     kill current request (branch/trap)
//  busy          out  1     stall request to pipeline
//  done          out  1     one-cycle pulse; result valid this cycle
//  result        out  XLEN  selected quotient or remainder
//  div_en        out  1     one-cycle launch pulse to divider
//  div_a/div_b   out  XLEN  registered operands to divider
//  div_signed    out  1     signed mode to divider
//  div_ready     in   1     divider finished
//  div_q/div_r   in   XLEN  divider quotient/remainder
// BEHAVIOUR
//  Reset: every output 0, state IDLE, cache invalid. Reset is honoured mid-operation: divider result is discarded.
//  busy = req_valid & ~done; busy is 0 while nrst is low.
//  States:
//   IDLE   : req_valid & ~flush accepts the request; operands and funct3 are latched.
//            Fast path -> DONE. Otherwise -> LAUNCH.
//   LAUNCH : div_en=1 for exactly one cycle -> WAIT.
//   WAIT   : on div_ready, capture q/r, update cache -> DONE. flush -> DRAIN.
//   DRAIN  : divider is not abortable. Wait for div_ready, discard, invalidate cache -> IDLE.
//            busy stays high for any new request during DRAIN.
//   DONE   : done=1, result registered -> IDLE. Pipeline advances on the same edge.
//  Fast paths (no div_en), priority order:
//   - rs2==0: q=all ones, r=rs1 (both signed and unsigned).
//   - signed, rs1==0x80000000, rs2==0xFFFFFFFF: q=0x80000000, r=0.
//   - cache hit (CACHE_EN, valid, a/b/signed equal): cached q/r.
//  Latency: fast path done on 2nd edge after acceptance. Divider path: accept, LAUNCH, WAIT(n), DONE.
//  div_ready in the LAUNCH cycle is ignored; only div_ready in WAIT/DRAIN counts.
//  Signedness: DIV/REM signed, DIVU/REMU unsigned. Result selection: funct3[1]=1 -> remainder.
//  flush in IDLE/LAUNCH/DONE:
//   - the request is dropped and done is suppressed.
//   - flush in LAUNCH still issues div_en, then -> DRAIN.
//  Simultaneous flush and div_ready in WAIT: result discarded -> IDLE.
// STRUCTURE
//  Shared package: funct3 constants (DIV/DIVU/REM/REMU), state enum, XLEN.
//  Sub-module div_result_cache: valid bit, a/b/signed tags, q/r storage, hit compare, invalidate.
// TESTING
//  DIV 100/7:
//   - one div_en pulse, result 14.
//   - then REM 100/7: no div_en, result 2, done 2 edges after accept.
//  DIVU 10/0 -> no div_en, result 0xFFFFFFFF; REMU 10/0 -> result 10.
//  DIV 0x80000000/0xFFFFFFFF -> no div_en, 0x80000000; REM same -> 0.
//  DIVU 0xFFFFFFFF/3, flush in WAIT:
//   - no done; REMU 7/2 stalls until old div_ready.
//   - then new div_en (cache miss), result 1.
//  nrst low during WAIT:
//   - all outputs 0 immediately.
//   - DIV 0xFFFFFFF9/2 (-7/2) -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
//  DIV 0xFFFFFFF0/2 -> 0xFFFFFFF8; REMU same operands -> cache miss, div_en pulses, result 0.

Source files
------------

// File: rtl/div_issue_ctrl_pkg.sv
// Shared constants for the RV32M divide issue controller: funct3 encodings,
// FSM state codes and operand width.
package div_issue_ctrl_pkg;

  localparam int DIV_XLEN = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LAUNCH = 3'd1;
  localparam state_t S_WAIT   = 3'd2;
  localparam state_t S_DRAIN  = 3'd3;
  localparam state_t S_DONE   = 3'd4;

  function automatic logic f3_signed(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic f3_rem(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

endpackage

// File: rtl/div_result_cache.sv
// One-entry memo of the last divider result, tagged by operands and signedness,
// so that a DIV followed by REM on the same operands skips the divider.
module div_result_cache #(
  parameter int XLEN     = 32,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [XLEN-1:0] lkp_a,
  input  logic [XLEN-1:0] lkp_b,
  input  logic            lkp_signed,
  output logic            hit,
  output logic [XLEN-1:0] hit_q,
  output logic [XLEN-1:0] hit_r,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_a,
  input  logic [XLEN-1:0] wr_b,
  input  logic            wr_signed,
  input  logic [XLEN-1:0] wr_q,
  input  logic [XLEN-1:0] wr_r,
  input  logic            inval
);

  logic            valid;
  logic            tag_signed;
  logic [XLEN-1:0] tag_a;
  logic [XLEN-1:0] tag_b;
  logic [XLEN-1:0] q_st;
  logic [XLEN-1:0] r_st;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid      <= 1'b0;
      tag_signed <= 1'b0;
      tag_a      <= '0;
      tag_b      <= '0;
      q_st       <= '0;
      r_st       <= '0;
    end else if (inval) begin
      valid <= 1'b0;
    end else if (wr_en) begin
      valid      <= 1'b1;
      tag_signed <= wr_signed;
      tag_a      <= wr_a;
      tag_b      <= wr_b;
      q_st       <= wr_q;
      r_st       <= wr_r;
    end
  end

  assign hit   = CACHE_EN && valid && (lkp_a == tag_a) && (lkp_b == tag_b) &&
                 (lkp_signed == tag_signed);
  assign hit_q = q_st;
  assign hit_r = r_st;

endmodule

// File: rtl/div_issue_ctrl.sv
// Execute-stage front end for DIV/DIVU/REM/REMU: resolves trivial cases locally,
// otherwise launches the multi-cycle divider and stalls until it answers.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int XLEN     = DIV_XLEN,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            req_valid,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            div_en,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  output logic            div_signed,
  input  logic            div_ready,
  input  logic [XLEN-1:0] div_q,
  input  logic [XLEN-1:0] div_r,
  output state_t          dbg_state
);

  // Handshake: req_valid stays high until done; done pulses for one cycle and the
  // pipeline advances on the edge that ends it. div_ready only counts in WAIT/DRAIN.

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic [2:0]      f3_q;
  logic            req_signed;
  logic            div0;
  logic            ovf;
  logic            hit;
  logic            fast;
  logic            accept;
  logic [XLEN-1:0] hit_q;
  logic [XLEN-1:0] hit_r;
  logic [XLEN-1:0] fast_q;
  logic [XLEN-1:0] fast_r;

  assign req_signed = f3_signed(funct3);
  assign div0       = (rs2_val == '0);
  assign ovf        = req_signed && (rs1_val == MIN_NEG) && (rs2_val == '1);
  assign fast       = div0 || ovf || hit;
  assign accept     = (state == S_IDLE) && req_valid && !flush;

  // Priority: divide-by-zero, then signed overflow, then cached result.
  always_comb begin
    fast_q = hit_q;
    fast_r = hit_r;
    if (div0) begin
      fast_q = '1;
      fast_r = rs1_val;
    end else if (ovf) begin
      fast_q = MIN_NEG;
      fast_r = '0;
    end
  end

  div_result_cache #(
    .XLEN     (XLEN),
    .CACHE_EN (CACHE_EN)
  ) u_cache (
    .clk        (clk),
    .nrst       (nrst),
    .lkp_a      (rs1_val),
    .lkp_b      (rs2_val),
    .lkp_signed (req_signed),
    .hit        (hit),
    .hit_q      (hit_q),
    .hit_r      (hit_r),
    .wr_en      ((state == S_WAIT) && div_ready && !flush),
    .wr_a       (div_a),
    .wr_b       (div_b),
    .wr_signed  (div_signed),
    .wr_q       (div_q),
    .wr_r       (div_r),
    .inval      ((state == S_DRAIN) && div_ready)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= S_IDLE;
      f3_q       <= '0;
      div_a      <= '0;
      div_b      <= '0;
      div_signed <= 1'b0;
      result     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            f3_q       <= funct3;
            div_a      <= rs1_val;
            div_b      <= rs2_val;
            div_signed <= req_signed;
            if (fast) begin
              result <= f3_rem(funct3) ? fast_r : fast_q;
              state  <= S_DONE;
            end else begin
              state <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: state <= flush ? S_DRAIN : S_WAIT;
        S_WAIT: begin
          // A flush racing the divider answer drops the result outright.
          if (flush) begin
            state <= div_ready ? S_IDLE : S_DRAIN;
          end else if (div_ready) begin
            result <= f3_rem(f3_q) ? div_r : div_q;
            state  <= S_DONE;
          end
        end
        S_DRAIN: if (div_ready) state <= S_IDLE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign div_en    = (state == S_LAUNCH);
  assign done      = (state == S_DONE) && !flush;
  assign busy      = nrst && req_valid && !done;
  assign dbg_state = state;

endmodule
